// File: rtl/pulse_peak_detector_if.sv
// Sample-stream inputs and event-record outputs of the pulse peak detector.
// The slave modport is the detector's view; the master modport is the sample source and event consumer.
interface pulse_peak_detector_if #(
  parameter int WIDTH = 12
);
  logic                    sampl_freq;
  logic signed [WIDTH-1:0] data_in;
  logic signed [WIDTH-1:0] threshold;
  logic                    event_ready;
  logic                    event_valid;
  logic signed [WIDTH-1:0] peak_value;
  logic [7:0]              peak_index;
  logic [7:0]              pulse_len;
  logic [7:0]              missed_count;
  logic                    busy;

  modport master (
    output sampl_freq, data_in, threshold, event_ready,
    input  event_valid, peak_value, peak_index, pulse_len, missed_count, busy
  );

  modport slave (
    input  sampl_freq, data_in, threshold, event_ready,
    output event_valid, peak_value, peak_index, pulse_len, missed_count, busy
  );
endinterface

// File: rtl/pulse_peak_detector.sv
// Tracks peak and length of each excursion above threshold; event is valid one clock after the terminating sample.
// A single output register: an event completing while it is full and not draining is dropped and counted.
module pulse_peak_detector #(
  parameter int WIDTH   = 12,
  parameter int HOLDOFF = 4
) (
  input logic                  clk,
  input logic                  reset,
  pulse_peak_detector_if.slave ifc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_HOLDOFF
  } state_t;

  typedef struct packed {
    logic signed [WIDTH-1:0] peak;
    logic [7:0]              idx;
    logic [7:0]              len;
  } evt_t;

  localparam bit          HOLD_EN   = (HOLDOFF != 0);
  localparam logic [15:0] HOLD_INIT = 16'(HOLDOFF);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_sf_prev;
  logic                    w_accept;
  logic signed [WIDTH-1:0] r_thr;
  logic signed [WIDTH-1:0] w_thr_nxt;
  evt_t                    r_acc;
  evt_t                    w_acc_nxt;
  logic [7:0]              r_off;
  logic [7:0]              w_off_nxt;
  logic [15:0]             r_hold;
  logic [15:0]             w_hold_nxt;
  logic                    w_trig;
  logic                    w_above;
  logic                    w_evt_done;

  evt_t                    r_out;
  logic                    r_evt_vld;
  logic [7:0]              r_missed;
  logic                    w_xfer;
  logic                    w_load;

  assign w_accept = ifc.sampl_freq & ~r_sf_prev;
  assign w_trig   = $signed(ifc.data_in) > $signed(ifc.threshold);
  assign w_above  = $signed(ifc.data_in) > $signed(r_thr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sf_prev <= 1'b0;
      r_state   <= S_IDLE;
      r_thr     <= '0;
      r_acc     <= '0;
      r_off     <= '0;
      r_hold    <= '0;
    end else begin
      r_sf_prev <= ifc.sampl_freq;
      r_state   <= w_state_nxt;
      r_thr     <= w_thr_nxt;
      r_acc     <= w_acc_nxt;
      r_off     <= w_off_nxt;
      r_hold    <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_thr_nxt   = r_thr;
    w_acc_nxt   = r_acc;
    w_off_nxt   = r_off;
    w_hold_nxt  = r_hold;
    w_evt_done  = 1'b0;
    if (w_accept) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            w_state_nxt   = S_ACTIVE;
            w_thr_nxt     = ifc.threshold;
            w_acc_nxt.peak = ifc.data_in;
            w_acc_nxt.idx = 8'd0;
            w_acc_nxt.len = 8'd1;
            w_off_nxt     = 8'd1;
          end
        end
        S_ACTIVE: begin
          if (w_above) begin
            w_acc_nxt.len = sat_inc(r_acc.len);
            // Strict compare: on ties the earliest maximum keeps its index.
            if ($signed(ifc.data_in) > $signed(r_acc.peak)) begin
              w_acc_nxt.peak = ifc.data_in;
              w_acc_nxt.idx  = r_off;
            end
            w_off_nxt = sat_inc(r_off);
          end else begin
            w_evt_done = 1'b1;
            if (HOLD_EN) begin
              w_state_nxt = S_HOLDOFF;
              w_hold_nxt  = HOLD_INIT;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        S_HOLDOFF: begin
          if (r_hold <= 16'd1) begin
            w_hold_nxt  = 16'd0;
            w_state_nxt = S_IDLE;
          end else begin
            w_hold_nxt = r_hold - 16'd1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // A transfer on the same edge frees the register for the completing event.
  assign w_xfer = r_evt_vld & ifc.event_ready;
  assign w_load = w_evt_done & (~r_evt_vld | w_xfer);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out     <= '0;
      r_evt_vld <= 1'b0;
      r_missed  <= '0;
    end else begin
      if (w_load) begin
        r_out     <= r_acc;
        r_evt_vld <= 1'b1;
      end else begin
        if (w_xfer) begin
          r_evt_vld <= 1'b0;
        end
        if (w_evt_done) begin
          r_missed <= sat_inc(r_missed);
        end
      end
    end
  end

  assign ifc.event_valid  = r_evt_vld;
  assign ifc.peak_value   = r_out.peak;
  assign ifc.peak_index   = r_out.idx;
  assign ifc.pulse_len    = r_out.len;
  assign ifc.missed_count = r_missed;
  assign ifc.busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_pulse_peak_detector.sv
// Scenario bench for pulse_peak_detector: expected events are queued as stimulus is driven,
// transfers are captured at the falling edge and compared against the queue.
module tb_pulse_peak_detector;

  typedef struct packed {
    logic [11:0] peak;
    logic [7:0]  idx;
    logic [7:0]  len;
  } evt_t;

  logic clk = 1'b0;
  logic reset;

  pulse_peak_detector_if #(.WIDTH(12)) ifc ();

  pulse_peak_detector #(.WIDTH(12), .HOLDOFF(4)) dut (
    .clk  (clk),
    .reset(reset),
    .ifc  (ifc)
  );

  always #5 clk = ~clk;

  evt_t exp_q[$];
  evt_t act_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Inputs only change 1 time unit after a rising edge, so vld/rdy here are what the next edge sees.
  always @(negedge clk)
    if (reset === 1'b0 && ifc.event_valid === 1'b1 && ifc.event_ready === 1'b1)
      act_q.push_back({ifc.peak_value, ifc.peak_index, ifc.pulse_len});

  function automatic evt_t mk(input int p, input int i, input int l);
    evt_t e;
    e.peak = 12'(p);
    e.idx  = 8'(i);
    e.len  = 8'(l);
    return e;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int v);
    ifc.data_in    = 12'(v);
    ifc.sampl_freq = 1'b1;
    step(10);
    ifc.sampl_freq = 1'b0;
    step(10);
  endtask

  task automatic settle();
    repeat (4) send(0);
  endtask

  task automatic test_reset();
    evt_t e, a;
    ifc.event_ready = 1'b0;
    send(200);
    send(50);
    send(300);
    ifc.sampl_freq = 1'b1;
    ifc.data_in    = 12'd150;
    step(3);
    reset = 1'b1;
    step(2);
    n_cmp++;
    if ({ifc.event_valid, ifc.peak_value, ifc.peak_index, ifc.pulse_len, ifc.missed_count, ifc.busy} !== 30'd0) begin
      n_fail++;
      $display("FAIL rst_outputs got vld=%0d peak=%0d idx=%0d len=%0d miss=%0d busy=%0d exp all 0",
               ifc.event_valid, ifc.peak_value, ifc.peak_index, ifc.pulse_len, ifc.missed_count, ifc.busy);
    end
    ifc.event_ready = 1'b1;
    reset = 1'b0;
    step(1);
    n_cmp++;
    if (ifc.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_first_edge got busy=%0d exp 1", ifc.busy);
    end
    step(9);
    ifc.sampl_freq = 1'b0;
    step(10);
    exp_q.push_back(mk(150, 0, 1));
    send(50);
    settle();
    n_cmp++;
    if (act_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rst_count got %0d exp %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL rst_evt got %0d/%0d/%0d exp %0d/%0d/%0d", a.peak, a.idx, a.len, e.peak, e.idx, e.len);
      end
    end
    exp_q.delete();
    act_q.delete();
  endtask

  task automatic test_single_pulse();
    evt_t e, a;
    ifc.event_ready = 1'b1;
    send(50);
    send(150);
    send(300);
    send(200);
    send(120);
    exp_q.push_back(mk(300, 1, 4));
    n_cmp++;
    if (ifc.event_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pre_vld got %0d exp 0", ifc.event_valid);
    end
    ifc.data_in    = 12'd80;
    ifc.sampl_freq = 1'b1;
    step(1);
    n_cmp++;
    if ({ifc.event_valid, ifc.peak_value, ifc.peak_index, ifc.pulse_len} !== {1'b1, 12'd300, 8'd1, 8'd4}) begin
      n_fail++;
      $display("FAIL single_rise got vld=%0d %0d/%0d/%0d exp vld=1 300/1/4",
               ifc.event_valid, ifc.peak_value, ifc.peak_index, ifc.pulse_len);
    end
    step(1);
    n_cmp++;
    if ({ifc.event_valid, ifc.peak_value, ifc.peak_index, ifc.pulse_len} !== {1'b0, 12'd300, 8'd1, 8'd4}) begin
      n_fail++;
      $display("FAIL single_fall got vld=%0d %0d/%0d/%0d exp vld=0 300/1/4 held",
               ifc.event_valid, ifc.peak_value, ifc.peak_index, ifc.pulse_len);
    end
    step(8);
    ifc.sampl_freq = 1'b0;
    step(10);
    settle();
    n_cmp++;
    if (act_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL single_count got %0d exp %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL single_evt got %0d/%0d/%0d exp %0d/%0d/%0d", a.peak, a.idx, a.len, e.peak, e.idx, e.len);
      end
    end
    exp_q.delete();
    act_q.delete();
  endtask

  task automatic test_tie();
    evt_t e, a;
    ifc.event_ready = 1'b1;
    send(150);
    send(300);
    send(300);
    exp_q.push_back(mk(300, 1, 3));
    send(100);
    settle();
    n_cmp++;
    if (act_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL tie_count got %0d exp %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL tie_evt got %0d/%0d/%0d exp %0d/%0d/%0d", a.peak, a.idx, a.len, e.peak, e.idx, e.len);
      end
    end
    exp_q.delete();
    act_q.delete();
  endtask

  task automatic test_backpressure();
    evt_t e, a;
    ifc.event_ready = 1'b0;
    send(200);
    exp_q.push_back(mk(200, 0, 1));
    send(50);
    settle();
    send(400);
    send(50);
    n_cmp++;
    if ({ifc.event_valid, ifc.peak_value, ifc.missed_count} !== {1'b1, 12'd200, 8'd1}) begin
      n_fail++;
      $display("FAIL bp_hold got vld=%0d peak=%0d miss=%0d exp vld=1 peak=200 miss=1",
               ifc.event_valid, ifc.peak_value, ifc.missed_count);
    end
    settle();
    ifc.event_ready = 1'b1;
    step(1);
    ifc.event_ready = 1'b0;
    n_cmp++;
    if ({ifc.event_valid, ifc.peak_value} !== {1'b0, 12'd200}) begin
      n_fail++;
      $display("FAIL bp_drain got vld=%0d peak=%0d exp vld=0 peak=200", ifc.event_valid, ifc.peak_value);
    end
    send(250);
    exp_q.push_back(mk(250, 0, 1));
    send(50);
    settle();
    send(400);
    exp_q.push_back(mk(400, 0, 1));
    ifc.data_in     = 12'd50;
    ifc.sampl_freq  = 1'b1;
    ifc.event_ready = 1'b1;
    step(1);
    n_cmp++;
    if ({ifc.event_valid, ifc.peak_value, ifc.missed_count} !== {1'b1, 12'd400, 8'd1}) begin
      n_fail++;
      $display("FAIL bp_same_edge got vld=%0d peak=%0d miss=%0d exp vld=1 peak=400 miss=1",
               ifc.event_valid, ifc.peak_value, ifc.missed_count);
    end
    step(9);
    ifc.sampl_freq = 1'b0;
    step(10);
    settle();
    n_cmp++;
    if (act_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL bp_count got %0d exp %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL bp_evt got %0d/%0d/%0d exp %0d/%0d/%0d", a.peak, a.idx, a.len, e.peak, e.idx, e.len);
      end
    end
    exp_q.delete();
    act_q.delete();
  endtask

  task automatic test_holdoff();
    evt_t e, a;
    ifc.event_ready = 1'b1;
    send(200);
    exp_q.push_back(mk(200, 0, 1));
    send(50);
    for (int i = 0; i < 3; i++) begin
      send(500);
      n_cmp++;
      if (ifc.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_busy_%0d got %0d exp 1", i, ifc.busy);
      end
    end
    ifc.data_in    = 12'd500;
    ifc.sampl_freq = 1'b1;
    n_cmp++;
    if (ifc.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_busy_3 got %0d exp 1", ifc.busy);
    end
    step(10);
    ifc.sampl_freq = 1'b0;
    step(10);
    exp_q.push_back(mk(500, 0, 1));
    send(500);
    n_cmp++;
    if (ifc.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_retrig got busy=%0d exp 1", ifc.busy);
    end
    send(50);
    settle();
    n_cmp++;
    if (act_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL hold_count got %0d exp %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL hold_evt got %0d/%0d/%0d exp %0d/%0d/%0d", a.peak, a.idx, a.len, e.peak, e.idx, e.len);
      end
    end
    exp_q.delete();
    act_q.delete();
  endtask

  task automatic test_long_pulse();
    evt_t e, a;
    ifc.event_ready = 1'b1;
    exp_q.push_back(mk(200, 0, 255));
    repeat (300) send(200);
    send(50);
    settle();
    repeat (149) send(200);
    ifc.data_in    = 12'd200;
    ifc.sampl_freq = 1'b1;
    step(10);
    ifc.sampl_freq = 1'b0;
    step(2);
    reset = 1'b1;
    step(2);
    n_cmp++;
    if ({ifc.event_valid, ifc.busy, ifc.pulse_len, ifc.missed_count} !== 18'd0) begin
      n_fail++;
      $display("FAIL long_rst got vld=%0d busy=%0d len=%0d miss=%0d exp all 0",
               ifc.event_valid, ifc.busy, ifc.pulse_len, ifc.missed_count);
    end
    reset = 1'b0;
    step(6);
    send(50);
    n_cmp++;
    if ({ifc.busy, ifc.event_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL long_idle got busy=%0d vld=%0d exp 0 0", ifc.busy, ifc.event_valid);
    end
    exp_q.push_back(mk(180, 0, 1));
    send(180);
    send(50);
    settle();
    n_cmp++;
    if (act_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL long_count got %0d exp %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL long_evt got %0d/%0d/%0d exp %0d/%0d/%0d", a.peak, a.idx, a.len, e.peak, e.idx, e.len);
      end
    end
    exp_q.delete();
    act_q.delete();
  endtask

  initial begin
    reset           = 1'b1;
    ifc.sampl_freq  = 1'b0;
    ifc.data_in     = '0;
    ifc.threshold   = 12'd100;
    ifc.event_ready = 1'b0;
    step(3);
    n_cmp++;
    if ({ifc.event_valid, ifc.peak_value, ifc.peak_index, ifc.pulse_len, ifc.missed_count, ifc.busy} !== 30'd0) begin
      n_fail++;
      $display("FAIL init_reset got vld=%0d peak=%0d idx=%0d len=%0d miss=%0d busy=%0d exp all 0",
               ifc.event_valid, ifc.peak_value, ifc.peak_index, ifc.pulse_len, ifc.missed_count, ifc.busy);
    end
    reset = 1'b0;
    step(2);

    test_reset();
    test_single_pulse();
    test_tie();
    test_backpressure();
    test_holdoff();
    test_long_pulse();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
